// File: rtl/bus_uart_pkg.sv
// bus_uart_pkg: shared definitions for the bus_uart peripheral.
//   - register offsets within the 8-byte window (addr[2:0])
//   - STATUS and CTRL bit indices, CTRL reset value
//   - bus handshake state enum and serial (TX/RX) state enum
package bus_uart_pkg;

  localparam int DATA_W = 8;

  localparam logic [2:0] REG_DATA   = 3'd0;
  localparam logic [2:0] REG_STATUS = 3'd1;
  localparam logic [2:0] REG_DIV_LO = 3'd2;
  localparam logic [2:0] REG_DIV_HI = 3'd3;
  localparam logic [2:0] REG_CTRL   = 3'd4;

  localparam int ST_TX_FULL    = 0;
  localparam int ST_TX_EMPTY   = 1;
  localparam int ST_RX_AVAIL   = 2;
  localparam int ST_RX_OVERRUN = 3;
  localparam int ST_TX_BUSY    = 4;
  localparam int ST_FRAME_ERR  = 5;

  localparam int CTRL_TX_EN     = 0;
  localparam int CTRL_RX_EN     = 1;
  localparam int CTRL_IRQ_RX_EN = 2;
  localparam int CTRL_IRQ_TX_EN = 3;

  localparam logic [3:0] CTRL_RESET = 4'b0011;

  typedef enum logic {
    BUS_IDLE,
    BUS_ACK
  } bus_state_e;

  typedef enum logic [1:0] {
    SER_IDLE,
    SER_START,
    SER_DATA,
    SER_STOP
  } ser_state_e;

endpackage

// File: rtl/bus_uart_fifo.sv
// bus_uart_fifo: small synchronous show-ahead FIFO.
// Ports:
//   clk, rstb      clock, asynchronous active-low reset (empties the FIFO)
//   push, din      write request and data; ignored when full unless a pop
//                  happens on the same edge
//   pop            read request; ignored when empty
//   dout           head entry (valid while !empty)
//   full, empty    occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
module bus_uart_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              push_ok;
  logic              pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign pop_ok  = pop & ~empty;
  // When full, a simultaneous pop frees the head slot, which is exactly
  // the slot wr_ptr points at, so the push can proceed.
  assign push_ok = push & (~full | pop_ok);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/bus_uart.sv
// bus_uart: memory-mapped 8N1 UART on the CPU byte bus.
// Parameters: BASE (window base, 8-byte window), CLK_DIV (reset divisor,
//   bit time = DIV+1 clocks), FIFO_DEPTH (entries per TX/RX FIFO).
// Ports:
//   clk, rstb           clock, asynchronous active-low reset
//   valid, write, addr, wdata   four-phase CPU request
//   ready, rdata        acknowledge and read data (rdata held until next read)
//   txd                 serial out, idle high
//   rxd                 serial in, asynchronous to clk
//   irq                 level interrupt
// Registers (addr[2:0]): 0 DATA, 1 STATUS, 2 DIV_LO, 3 DIV_HI, 4 CTRL.
// Build option: define BUS_UART_IRQ_EN to include the interrupt logic and
//   CTRL bits 2/3; otherwise irq is tied low and those bits read 0.
module bus_uart
  import bus_uart_pkg::*;
#(
  parameter logic [15:0] BASE       = 16'h1010,
  parameter logic [15:0] CLK_DIV    = 16'd103,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              valid,
  input  logic              write,
  input  logic [15:0]       addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic [DATA_W-1:0] rdata,
  output logic              txd,
  input  logic              rxd,
  output logic              irq
);

  // ---------------------------------------------------------------- bus
  bus_state_e        bus_state, bus_next;
  logic              hit;
  logic [2:0]        off;
  logic              access, wr_acc, rd_acc;
  logic [DATA_W-1:0] rd_val;
  logic [DATA_W-1:0] status;

  logic [15:0]       div_reg;
  logic [3:0]        ctrl;
  logic              rx_overrun, frame_err;

  // TX side
  ser_state_e        tx_state, tx_next;
  logic [15:0]       tx_cnt;
  logic [2:0]        tx_idx;
  logic [DATA_W-1:0] tx_shift;
  logic              tx_tick, tx_start, txd_nxt, tx_busy;
  logic              tx_push;
  logic [DATA_W-1:0] tx_dout;
  logic              tx_full, tx_empty;

  // RX side
  ser_state_e        rx_state, rx_next;
  logic [15:0]       rx_cnt;
  logic [2:0]        rx_idx;
  logic [DATA_W-1:0] rx_shift;
  logic              rx_s1, rx_s2, rx_prev;
  logic              rx_tick, rx_fall, rx_stop, rx_good;
  logic              rx_vld_p1;
  logic              rx_pop, rx_pop_ok;
  logic [DATA_W-1:0] rx_dout;
  logic              rx_full, rx_empty, rx_avail;
  logic              ovr_set, fe_set;

  assign hit    = (addr[15:3] == BASE[15:3]);
  assign off    = addr[2:0];
  assign access = (bus_state == BUS_IDLE) & valid & hit;
  assign wr_acc = access & write;
  assign rd_acc = access & ~write;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) bus_state <= BUS_IDLE;
    else       bus_state <= bus_next;
  end

  always_comb begin
    bus_next = bus_state;
    case (bus_state)
      BUS_IDLE: if (valid && hit) bus_next = BUS_ACK;
      BUS_ACK:  if (!valid)       bus_next = BUS_IDLE;
      default:  bus_next = BUS_IDLE;
    endcase
  end

  always_comb begin
    ready = (bus_state == BUS_ACK);
  end

  always_comb begin
    status                = '0;
    status[ST_TX_FULL]    = tx_full;
    status[ST_TX_EMPTY]   = tx_empty;
    status[ST_RX_AVAIL]   = rx_avail;
    status[ST_RX_OVERRUN] = rx_overrun;
    status[ST_TX_BUSY]    = tx_busy;
    status[ST_FRAME_ERR]  = frame_err;
  end

  always_comb begin
    rd_val = '0;
    case (off)
      REG_DATA:   rd_val = rx_empty ? '0 : rx_dout;
      REG_STATUS: rd_val = status;
      REG_DIV_LO: rd_val = div_reg[7:0];
      REG_DIV_HI: rd_val = div_reg[15:8];
      REG_CTRL:   rd_val = {4'b0000, ctrl};
      default:    rd_val = '0;
    endcase
  end

  // Register file and sticky flags; set events win over a same-edge clear.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      rdata      <= '0;
      div_reg    <= CLK_DIV;
      ctrl       <= CTRL_RESET;
      rx_overrun <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      if (rd_acc) rdata <= rd_val;
      if (wr_acc) begin
        case (off)
          REG_STATUS: begin
            if (wdata[ST_RX_OVERRUN]) rx_overrun <= 1'b0;
            if (wdata[ST_FRAME_ERR])  frame_err  <= 1'b0;
          end
          REG_DIV_LO: div_reg[7:0]  <= wdata;
          REG_DIV_HI: div_reg[15:8] <= wdata;
`ifdef BUS_UART_IRQ_EN
          REG_CTRL:   ctrl <= wdata[3:0];
`else
          REG_CTRL:   ctrl <= {2'b00, wdata[1:0]};
`endif
          default: ;
        endcase
      end
      if (ovr_set) rx_overrun <= 1'b1;
      if (fe_set)  frame_err  <= 1'b1;
    end
  end

  // ---------------------------------------------------------------- TX
  assign tx_push  = wr_acc & (off == REG_DATA);
  assign tx_tick  = (tx_cnt == '0);
  assign tx_start = (tx_state == SER_IDLE) & ctrl[CTRL_TX_EN] & ~tx_empty;
  assign tx_busy  = (tx_state != SER_IDLE);

  bus_uart_fifo #(.DEPTH(FIFO_DEPTH), .DATA_W(DATA_W)) u_tx_fifo (
    .clk   (clk),
    .rstb  (rstb),
    .push  (tx_push),
    .pop   (tx_start),
    .din   (wdata),
    .dout  (tx_dout),
    .full  (tx_full),
    .empty (tx_empty)
  );

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) tx_state <= SER_IDLE;
    else       tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      SER_IDLE:  if (tx_start) tx_next = SER_START;
      SER_START: if (tx_tick) tx_next = SER_DATA;
      SER_DATA:  if (tx_tick && tx_idx == 3'd7) tx_next = SER_STOP;
      SER_STOP:  if (tx_tick) tx_next = SER_IDLE;
      default:   tx_next = SER_IDLE;
    endcase
  end

  always_comb begin
    txd_nxt = 1'b1;
    case (tx_state)
      SER_START: txd_nxt = 1'b0;
      SER_DATA:  txd_nxt = tx_shift[0];
      default:   txd_nxt = 1'b1;
    endcase
  end

  // The bit counter reloads from div_reg at every bit boundary, so a new
  // divisor is picked up at the next boundary.  txd is registered, which
  // puts the start bit two edges after the DATA write.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      tx_cnt <= '0;
      tx_idx <= '0;
      txd    <= 1'b1;
    end else begin
      txd <= txd_nxt;
      if (tx_state == SER_IDLE) begin
        if (tx_start) tx_cnt <= div_reg;
      end else if (tx_tick) begin
        tx_cnt <= div_reg;
      end else begin
        tx_cnt <= tx_cnt - 16'd1;
      end
      if (tx_state == SER_START)               tx_idx <= '0;
      else if (tx_state == SER_DATA && tx_tick) tx_idx <= tx_idx + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_start)                             tx_shift <= tx_dout;
    else if (tx_state == SER_DATA && tx_tick) tx_shift <= tx_shift >> 1;
  end

  // ---------------------------------------------------------------- RX
  assign rx_tick   = (rx_cnt == '0);
  assign rx_fall   = rx_prev & ~rx_s2;
  assign rx_stop   = (rx_state == SER_STOP) & rx_tick & ctrl[CTRL_RX_EN];
  assign rx_good   = rx_stop & rx_s2;
  assign fe_set    = rx_stop & ~rx_s2;
  assign rx_pop    = rd_acc & (off == REG_DATA);
  assign rx_pop_ok = rx_pop & ~rx_empty;
  assign ovr_set   = rx_vld_p1 & rx_full & ~rx_pop_ok;
  assign rx_avail  = ~rx_empty;

  bus_uart_fifo #(.DEPTH(FIFO_DEPTH), .DATA_W(DATA_W)) u_rx_fifo (
    .clk   (clk),
    .rstb  (rstb),
    .push  (rx_vld_p1),
    .pop   (rx_pop),
    .din   (rx_shift),
    .dout  (rx_dout),
    .full  (rx_full),
    .empty (rx_empty)
  );

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) rx_state <= SER_IDLE;
    else       rx_state <= rx_next;
  end

  always_comb begin
    rx_next = rx_state;
    if (!ctrl[CTRL_RX_EN]) begin
      rx_next = SER_IDLE;
    end else begin
      case (rx_state)
        SER_IDLE:  if (rx_fall) rx_next = SER_START;
        SER_START: if (rx_tick) rx_next = rx_s2 ? SER_IDLE : SER_DATA;
        SER_DATA:  if (rx_tick && rx_idx == 3'd7) rx_next = SER_STOP;
        SER_STOP:  if (rx_tick) rx_next = SER_IDLE;
        default:   rx_next = SER_IDLE;
      endcase
    end
  end

  // Synchronizer, half-bit arm for the start sample, and the one-cycle
  // delayed push so rx_avail rises on the edge after the stop sample.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      rx_s1     <= 1'b1;
      rx_s2     <= 1'b1;
      rx_prev   <= 1'b1;
      rx_cnt    <= '0;
      rx_idx    <= '0;
      rx_vld_p1 <= 1'b0;
    end else begin
      rx_s1     <= rxd;
      rx_s2     <= rx_s1;
      rx_prev   <= rx_s2;
      rx_vld_p1 <= rx_good;
      if (rx_state == SER_IDLE) begin
        if (rx_fall) rx_cnt <= div_reg >> 1;
      end else if (rx_tick) begin
        rx_cnt <= div_reg;
      end else begin
        rx_cnt <= rx_cnt - 16'd1;
      end
      if (rx_state == SER_START)               rx_idx <= '0;
      else if (rx_state == SER_DATA && rx_tick) rx_idx <= rx_idx + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rx_state == SER_DATA && rx_tick) rx_shift <= {rx_s2, rx_shift[DATA_W-1:1]};
  end

  // ---------------------------------------------------------------- irq
`ifdef BUS_UART_IRQ_EN
  assign irq = (ctrl[CTRL_IRQ_RX_EN] & rx_avail) |
               (ctrl[CTRL_IRQ_TX_EN] & tx_empty & ~tx_busy);
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_bus_uart.sv
module tb_bus_uart;
  import bus_uart_pkg::*;

  logic        clk, rstb, valid, write, rxd;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        ready, txd, irq;
  logic [7:0]  rdata;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fall_cyc = -1;
  int acc_cyc = 0;
  int nxact = 0;
  int rdy_rises = 0;
  int tb_div = 103;
  logic txd_q = 1'b1;

  logic [9:0] tx_got[$];
  logic [7:0] m_txq[$];
  logic [7:0] m_rxq[$];
  logic       m_ovr = 1'b0;
  logic       m_fe = 1'b0;

  bus_uart dut (
    .clk   (clk),
    .rstb  (rstb),
    .valid (valid),
    .write (write),
    .addr  (addr),
    .wdata (wdata),
    .ready (ready),
    .rdata (rdata),
    .txd   (txd),
    .rxd   (rxd),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge ready) rdy_rises <= rdy_rises + 1;
  always @(negedge clk) begin
    txd_q <= txd;
    if (txd_q && !txd) fall_cyc <= cyc;
  end

  // Line-level UART receiver watching txd: samples mid-bit.
  always begin : tx_mon
    logic [9:0] fr;
    @(negedge clk);
    if (rstb === 1'b1 && txd === 1'b0) begin
      repeat ((tb_div + 1) / 2) @(negedge clk);
      fr[0] = txd;
      for (int i = 1; i < 10; i++) begin
        repeat (tb_div + 1) @(negedge clk);
        fr[i] = txd;
      end
      tx_got.push_back(fr);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bus(input logic wr, input logic [2:0] o, input logic [7:0] d,
                     output logic [7:0] q);
    int n;
    @(negedge clk);
    valid = 1'b1; write = wr; addr = 16'h1010 + 16'(o); wdata = d;
    @(negedge clk);
    acc_cyc = cyc;
    n = 0;
    while (ready !== 1'b1 && n < 16) begin @(negedge clk); n++; end
    chk("ready_rise", ready, 1'b1);
    q = rdata;
    valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (ready !== 1'b0 && n < 16) begin @(negedge clk); n++; end
    chk("ready_fall", ready, 1'b0);
    nxact++;
  endtask

  task automatic reg_wr(input logic [2:0] o, input logic [7:0] d);
    logic [7:0] q;
    bus(1'b1, o, d, q);
  endtask

  task automatic reg_rd(input logic [2:0] o, output logic [7:0] q);
    bus(1'b0, o, 8'h00, q);
  endtask

  task automatic wait_tx_idle();
    logic [7:0] st;
    int n;
    n = 0;
    st = 8'h00;
    do begin
      reg_rd(REG_STATUS, st);
      n++;
    end while (((st & 8'h12) != 8'h02) && n < 300);
    chk("tx_idle_wait", (n < 300), 1'b1);
    repeat (12) @(negedge clk);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stopb);
    logic [9:0] fr;
    fr = {stopb, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = fr[i];
      repeat (tb_div + 1) @(negedge clk);
    end
    rxd = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  function automatic logic [7:0] exp_status();
    return {2'b00, m_fe, 1'b0, m_ovr, (m_rxq.size() != 0), 1'b1, 1'b0};
  endfunction

  initial begin
    logic [7:0] q, b, e;
    logic [9:0] fr;
    int n, r0;

    rstb = 1'b0; valid = 1'b0; write = 1'b0; addr = '0; wdata = '0; rxd = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready", ready, 1'b0);
    chk("rst_txd", txd, 1'b1);
    chk("rst_irq", irq, 1'b0);
    chk("rst_rdata", rdata, 8'h00);
    rstb = 1'b1;
    @(negedge clk);

    reg_rd(REG_STATUS, q); chk("rst_status", q, 8'h02);
    reg_rd(REG_CTRL, q);   chk("rst_ctrl", q, 8'h03);
    reg_rd(REG_DIV_LO, q); chk("rst_div_lo", q, 8'h67);
    reg_rd(REG_DIV_HI, q); chk("rst_div_hi", q, 8'h00);
    reg_wr(3'd6, 8'hFF);
    reg_rd(3'd6, q);       chk("reserved_rd", q, 8'h00);
    chk("ready_pulses_a", rdy_rises, nxact);

    // TX: fixed pattern 0xA5 at DIV=3, exact start latency.
    reg_wr(REG_DIV_LO, 8'd3);
    tb_div = 3;
    reg_wr(REG_DATA, 8'hA5);
    r0 = acc_cyc;
    repeat (3) @(negedge clk);
    chk("tx_start_lat", fall_cyc - r0, 2);
    wait_tx_idle();
    chk("tx_a5_count", tx_got.size(), 1);
    if (tx_got.size() > 0) begin
      fr = tx_got.pop_front();
      chk("tx_a5_bits", fr, 10'b1_10100101_0);
    end
    reg_rd(REG_STATUS, q); chk("tx_done_status", q, 8'h02);

    // TX: random bytes, FIFO fills while tx_en=0, 5th dropped.
    reg_wr(REG_CTRL, 8'h02);
    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom);
      reg_wr(REG_DATA, b);
      if (m_txq.size() < 4) m_txq.push_back(b);
    end
    reg_rd(REG_STATUS, q);
    e = {7'b0, (m_txq.size() == 4)};
    chk("tx_full_status", q, e);
    repeat (60) @(negedge clk);
    chk("tx_held", tx_got.size(), 0);
    reg_wr(REG_CTRL, 8'h03);
    wait_tx_idle();
    chk("tx_frame_count", tx_got.size(), m_txq.size());
    while (tx_got.size() > 0 && m_txq.size() > 0) begin
      fr = tx_got.pop_front();
      b = m_txq.pop_front();
      chk("tx_frame", fr, {1'b1, b, 1'b0});
    end

    // RX: single random frame at DIV=7.
    reg_wr(REG_DIV_LO, 8'd7);
    tb_div = 7;
    b = 8'($urandom);
    send_rx(b, 1'b1);
    m_rxq.push_back(b);
    reg_rd(REG_STATUS, q); chk("rx_avail_status", q, exp_status());
    reg_wr(REG_CTRL, 8'h0F);
    reg_rd(REG_CTRL, q);
`ifdef BUS_UART_IRQ_EN
    chk("ctrl_irq_bits", q, 8'h0F);
    chk("irq_rx", irq, 1'b1);
`else
    chk("ctrl_irq_bits", q, 8'h03);
    chk("irq_rx", irq, 1'b0);
`endif
    reg_wr(REG_CTRL, 8'h03);
    chk("irq_off", irq, 1'b0);
    reg_rd(REG_DATA, q);   chk("rx_data", q, m_rxq.pop_front());
    reg_rd(REG_DATA, q);   chk("rx_empty_read", q, 8'h00);
    reg_rd(REG_STATUS, q); chk("rx_drained_status", q, exp_status());

    // RX: overrun after 5 unread frames.
    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom);
      send_rx(b, 1'b1);
      if (m_rxq.size() < 4) m_rxq.push_back(b);
      else m_ovr = 1'b1;
    end
    reg_rd(REG_STATUS, q); chk("rx_overrun_status", q, exp_status());
    while (m_rxq.size() > 0) begin
      reg_rd(REG_DATA, q);
      chk("rx_fifo_data", q, m_rxq.pop_front());
    end
    reg_wr(REG_STATUS, 8'h08);
    m_ovr = 1'b0;
    reg_rd(REG_STATUS, q); chk("ovr_clear_status", q, exp_status());

    // RX: framing error, byte discarded.
    send_rx(8'($urandom), 1'b0);
    m_fe = 1'b1;
    reg_rd(REG_STATUS, q); chk("frame_err_status", q, exp_status());
    reg_wr(REG_STATUS, 8'h20);
    m_fe = 1'b0;
    reg_rd(REG_STATUS, q); chk("fe_clear_status", q, exp_status());

    // Non-hit request never acknowledged.
    n = rdy_rises;
    @(negedge clk);
    valid = 1'b1; write = 1'b0; addr = 16'h1000;
    repeat (6) @(negedge clk);
    chk("nohit_ready", ready, 1'b0);
    chk("nohit_pulses", rdy_rises, n);
    valid = 1'b0;
    chk("ready_pulses_b", rdy_rises, nxact);

    // Reset in the middle of a TX frame.
    reg_wr(REG_DATA, 8'($urandom));
    n = 0;
    while (txd !== 1'b0 && n < 20) begin @(negedge clk); n++; end
    chk("mid_tx_started", txd, 1'b0);
    repeat (2) @(negedge clk);
    rstb = 1'b0;
    #1;
    chk("rst_mid_txd", txd, 1'b1);
    chk("rst_mid_ready", ready, 1'b0);
    chk("rst_mid_rdata", rdata, 8'h00);
    #20;
    rstb = 1'b1;
    reg_rd(REG_STATUS, q); chk("post_rst_status", q, 8'h02);
    reg_rd(REG_DIV_LO, q); chk("post_rst_div", q, 8'h67);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
